// File: rtl/ps2_note_decoder.sv
// PS/2 Set-2 byte stream to synthesizer controls: held-note mask, saturating
// octave shift and mutually exclusive flat/sharp modes, with prefix timeout.
module ps2_note_decoder #(
  parameter int PREFIX_TIMEOUT = 2_500_000,
  parameter int OCT_MIN        = -4,
  parameter int OCT_MAX        = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        received_data,
  input  logic              received_data_en,
  output logic [6:0]        note_held,
  output logic signed [3:0] octave,
  output logic              flat,
  output logic              sharp,
  output logic              note_event,
  output logic              note_event_make,
  output logic [2:0]        note_event_idx,
  output logic [7:0]        last_byte
);

  localparam int               CW      = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0]    TO_LAST = CW'(PREFIX_TIMEOUT - 1);
  localparam logic signed [3:0] OCT_LO = 4'(OCT_MIN);
  localparam logic signed [3:0] OCT_HI = 4'(OCT_MAX);

  localparam logic [7:0] B_BREAK = 8'hF0;
  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_ESC   = 8'h76;
  localparam logic [7:0] B_UP    = 8'h75;
  localparam logic [7:0] B_DOWN  = 8'h72;
  localparam logic [7:0] B_LEFT  = 8'h6B;
  localparam logic [7:0] B_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tmo_cnt;
  logic            timeout_hit;
  logic            is_note;
  logic [2:0]      note_idx;

  logic [6:0]        held_nxt;
  logic signed [3:0] oct_nxt;
  logic              flat_nxt, sharp_nxt;
  logic              ev_nxt, ev_make_nxt;
  logic [2:0]        ev_idx_nxt;
  logic [7:0]        last_nxt;

  always_comb begin
    is_note  = 1'b1;
    note_idx = 3'd0;
    case (received_data)
      8'h16:   note_idx = 3'd6;
      8'h1E:   note_idx = 3'd5;
      8'h26:   note_idx = 3'd4;
      8'h25:   note_idx = 3'd3;
      8'h2E:   note_idx = 3'd2;
      8'h36:   note_idx = 3'd1;
      8'h3D:   note_idx = 3'd0;
      default: is_note  = 1'b0;
    endcase
  end

  // A strobe on the firing cycle suppresses the timeout so the byte is parsed in context.
  assign timeout_hit = (state != S_IDLE) && !received_data_en && (tmo_cnt == TO_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state == S_IDLE || received_data_en || timeout_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (received_data_en) begin
      case (state)
        S_IDLE: begin
          if (received_data == B_BREAK)    state_nxt = S_BRK;
          else if (received_data == B_EXT) state_nxt = S_EXT;
        end
        S_BRK: begin
          if (received_data == B_BREAK)    state_nxt = S_BRK;
          else if (received_data == B_EXT) state_nxt = S_EXT;
          else                             state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (received_data == B_BREAK) state_nxt = S_EXT_BRK;
          else                          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    held_nxt    = note_held;
    oct_nxt     = octave;
    flat_nxt    = flat;
    sharp_nxt   = sharp;
    ev_nxt      = 1'b0;
    ev_make_nxt = 1'b0;
    ev_idx_nxt  = 3'd0;
    last_nxt    = received_data_en ? received_data : last_byte;
    if (received_data_en) begin
      case (state)
        S_IDLE: begin
          if (is_note && !note_held[note_idx]) begin
            held_nxt[note_idx] = 1'b1;
            ev_nxt             = 1'b1;
            ev_make_nxt        = 1'b1;
            ev_idx_nxt         = note_idx;
          end else if (received_data == B_ESC) begin
            held_nxt  = '0;
            oct_nxt   = '0;
            flat_nxt  = 1'b0;
            sharp_nxt = 1'b0;
          end
        end
        S_BRK: begin
          if (is_note && note_held[note_idx]) begin
            held_nxt[note_idx] = 1'b0;
            ev_nxt             = 1'b1;
            ev_idx_nxt         = note_idx;
          end
        end
        S_EXT: begin
          case (received_data)
            B_UP:    if (octave < OCT_HI) oct_nxt = octave + 4'sd1;
            B_DOWN:  if (octave > OCT_LO) oct_nxt = octave - 4'sd1;
            B_LEFT: begin
              flat_nxt = !flat;
              if (!flat) sharp_nxt = 1'b0;
            end
            B_RIGHT: begin
              sharp_nxt = !sharp;
              if (!sharp) flat_nxt = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      note_held       <= '0;
      octave          <= '0;
      flat            <= 1'b0;
      sharp           <= 1'b0;
      note_event      <= 1'b0;
      note_event_make <= 1'b0;
      note_event_idx  <= 3'd0;
      last_byte       <= 8'd0;
    end else begin
      note_held       <= held_nxt;
      octave          <= oct_nxt;
      flat            <= flat_nxt;
      sharp           <= sharp_nxt;
      note_event      <= ev_nxt;
      note_event_make <= ev_make_nxt;
      note_event_idx  <= ev_idx_nxt;
      last_byte       <= last_nxt;
    end
  end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Parses the PS/2 Set-2 byte stream from `PS2_Controller` into clean synthesizer controls. Tracks make/break (`F0`) and extended (`E0`) prefixes, so the downstream tone generators get a per-note held mask, a saturating octave shift and flat/sharp modes. Stray prefixes, typematic repeats and unrelated keys cannot corrupt that state. Sits between `PS2_Controller` and the note/tone-generation logic.

## Interface
Parameters:
- `PREFIX_TIMEOUT`, 2_500_000: clock cycles (50 ms at 50 MHz) a prefix state may wait for its next byte before abandoning to IDLE.
- `OCT_MIN`, -4: lowest octave value (signed).
- `OCT_MAX`, 4: highest octave value (signed).

Ports:
- `CLOCK_50`  in  1  the single system clock; all logic on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `received_data`  in  8  PS/2 byte; valid only while `received_data_en` is high.
- `received_data_en`  in  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- `note_held`  out  7  held-note mask. Bit 6=A(`16`), 5=B(`1E`), 4=C(`26`), 3=D(`25`), 2=E(`2E`), 1=F(`36`), 0=G(`3D`).
- `octave`  out  4  signed octave shift, range OCT_MIN..OCT_MAX.
- `flat`  out  1  flat mode.
- `sharp`  out  1  sharp mode.
- `note_event`  out  1  one-cycle pulse on each real held-mask change.
- `note_event_make`  out  1  qualifies `note_event`: 1 = press, 0 = release.
- `note_event_idx`  out  3  index (6..0, bit position in `note_held`) of the note for the current `note_event`.
- `last_byte`  out  8  most recent received byte, for HEX display.

## Operation
FSM states: IDLE, BRK (`F0` seen), EXT (`E0` seen), EXT_BRK (`E0 F0` seen).

All transitions occur only on a strobe, except the timeout.

**IDLE**
- `F0` -> BRK.
- `E0` -> EXT.
- Note code:
  - Bit clear: set the bit and pulse `note_event`, make=1.
  - Bit already set: typematic repeat; no change, no event.
- `76` (Esc): panic. Clear `note_held`, `octave`, `flat` and `sharp`; no note_event.
- Other bytes: ignored.

**BRK**
- Note code:
  - Bit set: clear the bit and pulse `note_event`, make=0.
  - Bit already clear: no event.
  - -> IDLE.
- `F0`: stay in BRK.
- `E0` -> EXT.
- Other bytes: -> IDLE, no effect.

**EXT**
- `75` (up): `octave`+1, saturating at OCT_MAX.
- `72` (down): `octave`-1, saturating at OCT_MIN.
- `6B` (left): toggle `flat`. Turning it on clears `sharp`.
- `74` (right): toggle `sharp`. Turning it on clears `flat`.
- `F0` -> EXT_BRK.
- Other bytes: -> IDLE, no effect.
- After any of `75`/`72`/`6B`/`74`: -> IDLE.

**EXT_BRK**
- Any byte -> IDLE. Arrow releases have no effect.

**Timeout**
- In any non-IDLE state, a counter increments every cycle without a strobe and clears on every strobe.
- When it reaches PREFIX_TIMEOUT-1: -> IDLE, counter cleared.
- The counter is held at 0 in IDLE.

**Other rules**
- `last_byte` loads on every strobe, regardless of state.
- Octave arithmetic is 4-bit signed. The saturation compare is done before the update, so wrap-around never occurs.

## Timing
- Reset values: state IDLE, `note_held`=0, `octave`=0, `flat`=0, `sharp`=0, `note_event`=0, `note_event_make`=0, `note_event_idx`=0, `last_byte`=0, timeout counter=0.
- All outputs are registered. The effect of a strobe at edge k is visible after edge k+1, so latency is 1 cycle.
- `note_event`, `note_event_make` and `note_event_idx` are valid together for exactly one cycle, coincident with the `note_held` update.
- Back-to-back strobes are each fully processed; no byte is dropped.
- A strobe arriving on the same cycle the timeout fires: the strobe wins. The byte is processed in the current state.
- A reset asserted mid-sequence (e.g. after `E0`) returns to IDLE immediately and asynchronously. A following `75` is then treated as an unrelated byte in IDLE.

## Test plan
- Press and release A: after reset, send `16` then `F0 16`. Required: `note_held`=7'b1000000 with one event (make=1, idx=6), then 0 with one event (make=0, idx=6).
- Typematic repeat and chord: send `26 26 26 3D`, then `F0 26`. Required:
  - Only two make events (C, then G).
  - `note_held`=7'b0010001, then 7'b0000001 after the release.
- Octave saturation: send `E0 75` six times. Required: `octave` steps 1,2,3,4,4,4. Then `E0 72` ×10 ends at -4 (4'b1100).
- Flat/sharp exclusivity:
  - `E0 6B` -> flat=1, sharp=0.
  - `E0 74` -> flat=0, sharp=1.
  - `E0 74` -> both 0.
  - `E0 F0 74` -> no change.
- Prefix timeout: send `F0`, idle PREFIX_TIMEOUT cycles, then `16`. Required: A becomes held (make event), not released. Repeat with the `16` arriving at cycle PREFIX_TIMEOUT-2: it is treated as a break.
- Reset and panic:
  - Assert `reset` between `E0` and `75`: outputs return to reset values asynchronously, and `75` has no effect.
  - Hold notes, set octave=2, then send `76`: all controls clear.
